// File: rtl/debounce_edge_detect.sv
// Synchronizes a raw asynchronous input, then debounces it with a counter FSM
// that yields a registered stable level plus one-cycle rise/fall pulses.
module debounce_edge_detect #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_stable,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] IdleLow  = 2'd0;
  localparam logic [1:0] ChkHigh  = 2'd1;
  localparam logic [1:0] IdleHigh = 2'd2;
  localparam logic [1:0] ChkLow   = 2'd3;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               Direct = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   sync_out;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], d_in};
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IdleLow: begin
        if (sync_out) begin
          if (Direct) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
            state_d = IdleHigh;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ChkHigh;
          end
        end
      end
      ChkHigh: begin
        if (!sync_out) begin
          // Glitch: discard the partial count entirely.
          cnt_d   = '0;
          state_d = IdleLow;
        end else if (cnt_q == CntMax) begin
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          state_d = IdleHigh;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IdleHigh: begin
        if (!sync_out) begin
          if (Direct) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
            state_d = IdleLow;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = ChkLow;
          end
        end
      end
      ChkLow: begin
        if (sync_out) begin
          cnt_d   = '0;
          state_d = IdleHigh;
        end else if (cnt_q == CntMax) begin
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
          state_d = IdleLow;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IdleLow;
      end
    endcase
    busy_d = (state_d == ChkHigh) || (state_d == ChkLow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IdleLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q_stable = level_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Drives a default and a DEBOUNCE_CYCLES=1 instance with directed and random
// input, checking both against a run-length model of the debounce rules.
module tb_debounce_edge_detect;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  logic d_in;
  logic q0, r0, f0, b0;
  logic q1, r1, f1, b1;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  debounce_edge_detect #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .q_stable(q0),
    .rise    (r0),
    .fall    (f0),
    .busy    (b0)
  );

  debounce_edge_detect #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(1),
    .CNT_W          (8)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .q_stable(q1),
    .rise    (r1),
    .fall    (f1),
    .busy    (b1)
  );

  // Model: the filter sees d_in delayed by SS edges; a level is accepted once
  // that delayed value disagrees with the current level for dc_m samples in a row.
  bit [SS-1:0] dly_m;
  int          run_m [2];
  bit          lvl_m [2];
  bit          rise_m[2];
  bit          fall_m[2];
  int          dc_m  [2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit d, input bit r);
    bit s;
    s = dly_m[SS-1];
    if (r) begin
      dly_m = '0;
      for (int i = 0; i < 2; i++) begin
        run_m[i] = 0; lvl_m[i] = 0; rise_m[i] = 0; fall_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rise_m[i] = 0;
        fall_m[i] = 0;
        if (s != lvl_m[i]) begin
          run_m[i]++;
          if (run_m[i] == dc_m[i]) begin
            lvl_m[i]  = s;
            rise_m[i] = s;
            fall_m[i] = !s;
            run_m[i]  = 0;
          end
        end else begin
          run_m[i] = 0;
        end
      end
      dly_m = {dly_m[SS-2:0], d};
    end
  endtask

  task automatic step(input logic d, input logic r);
    d_in = d;
    rst  = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    chk("q_stable0", q0, lvl_m[0]);
    chk("rise0",     r0, rise_m[0]);
    chk("fall0",     f0, fall_m[0]);
    chk("busy0",     b0, run_m[0] != 0);
    chk("q_stable1", q1, lvl_m[1]);
    chk("rise1",     r1, rise_m[1]);
    chk("fall1",     f1, fall_m[1]);
    chk("busy1",     b1, run_m[1] != 0);
    chk("no_both0",  r0 & f0, 1'b0);
  endtask

  initial begin
    int hold;
    logic dv;
    dc_m[0] = 4;
    dc_m[1] = 1;
    dly_m   = '0;
    d_in    = 1'b0;
    rst     = 1'b1;
    // Reset, then idle low.
    repeat (2) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    // Clean rise.
    repeat (10) step(1'b1, 1'b0);
    // Clean fall.
    repeat (10) step(1'b0, 1'b0);
    // Short high pulse rejected.
    repeat (3) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    // Reset in the middle of qualification, input held high.
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    // Random bursts with occasional reset.
    for (int n = 0; n < 300; n++) begin
      hold = $urandom_range(1, 8);
      dv   = 1'($urandom_range(0, 1));
      for (int k = 0; k < hold; k++) begin
        step(dv, ($urandom_range(0, 59) == 0));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
